// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - serial adder, one 4-bit carry-lookahead nibble per cycle
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    logic [1:0]       state;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     sum_reg;
    logic             carry;
    logic             cout_reg;
    logic             ovf_reg;
    logic [IDX_W-1:0] idx;

    logic [3:0] a_nib;
    logic [3:0] b_nib;
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    logic [3:0] nib_sum;

    always_comb begin
        a_nib = a_reg[{idx, 2'b00} +: 4];
        b_nib = b_reg[{idx, 2'b00} +: 4];
        g     = a_nib & b_nib;
        p     = a_nib | b_nib;
        c[0]  = carry;
        c[1]  = g[0] | (p[0] & c[0]);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
        c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
        nib_sum = a_nib ^ b_nib ^ c[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
            idx      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        carry   <= cin;
                        sum_reg <= '0;
                        idx     <= '0;
                        state   <= ADD;
                    end
                end
                ADD: begin
                    sum_reg[{idx, 2'b00} +: 4] <= nib_sum;
                    carry <= c[4];
                    idx   <= idx + 1'b1;
                    // Signed overflow needs the carry into the MSB, only visible on the top nibble.
                    if (idx == LAST_IDX) begin
                        cout_reg <= c[4];
                        ovf_reg  <= c[3] ^ c[4];
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 16'h0; b = 16'h0; cin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0})
            $display("FAIL reset_state: got rdy=%b vld=%b sum=%h cout=%b ovf=%b, want rdy=1 vld=0 sum=0000 cout=0 ovf=0",
                     in_ready, out_valid, sum, cout, ovf);
    endtask

    task automatic test_add(input logic [15:0] ta, input logic [15:0] tb_op, input logic tc,
                            input logic [15:0] es, input logic ec, input logic eo, input string nm);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; a = ta; b = tb_op; cin = tc;
        @(negedge clk);
        in_valid = 1'b0; a = ~ta; b = 16'h5A5A; cin = ~tc;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat != 4) begin
            n_bad++;
            $display("FAIL %s latency: got %0d edges, want 4", nm, lat);
        end
        n_cmp++;
        if ({cout, ovf, sum} !== {ec, eo, es}) begin
            n_bad++;
            $display("FAIL %s result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                     nm, sum, cout, ovf, es, ec, eo);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid, sum} !== {1'b1, 1'b0, es}) begin
            n_bad++;
            $display("FAIL %s release: got rdy=%b vld=%b sum=%h, want rdy=1 vld=0 sum=%h",
                     nm, in_ready, out_valid, sum, es);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        in_valid = 1'b1; a = 16'h00FF; b = 16'h0F01; cin = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({out_valid, in_ready, cout, ovf, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h1001}) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b sum=%h cout=%b ovf=%b, want vld=1 rdy=0 sum=1001 cout=0 ovf=0",
                         i, out_valid, in_ready, sum, cout, ovf);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL bp_idle: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        end
        in_valid = 1'b1; a = 16'h0001; b = 16'h0002; cin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_accept: got rdy=%b, want rdy=0", in_ready);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (sum !== 16'h0003 || lat != 4) begin
            n_bad++;
            $display("FAIL bp_next: got sum=%h lat=%0d, want sum=0003 lat=4", sum, lat);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid, sum, cout} !== {1'b1, 1'b0, 16'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_mid: got rdy=%b vld=%b sum=%h cout=%b, want rdy=1 vld=0 sum=0000 cout=0",
                     in_ready, out_valid, sum, cout);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL reset_mid_no_valid: got %0d valid cycles, want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] opa [3];
        logic [15:0] opb [3];
        logic        opc [3];
        logic [17:0] exp_r [3];
        int          acc_cyc [3];
        int          acc, got, cyc;
        logic        prev_ready;
        opa[0] = 16'h0F0F; opb[0] = 16'h0101; opc[0] = 1'b0; exp_r[0] = {1'b0, 1'b0, 16'h1010};
        opa[1] = 16'hABCD; opb[1] = 16'h1111; opc[1] = 1'b1; exp_r[1] = {1'b0, 1'b0, 16'hBCDF};
        opa[2] = 16'h9000; opb[2] = 16'h9000; opc[2] = 1'b0; exp_r[2] = {1'b1, 1'b1, 16'h2000};
        acc = 0; got = 0; cyc = 0;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        a = opa[0]; b = opb[0]; cin = opc[0];
        prev_ready = in_ready;
        while (got < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (prev_ready && in_valid) begin
                acc_cyc[acc] = cyc;
                acc++;
                if (acc < 3) begin
                    a = opa[acc]; b = opb[acc]; cin = opc[acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid === 1'b1) begin
                n_cmp++;
                if ({cout, ovf, sum} !== exp_r[got]) begin
                    n_bad++;
                    $display("FAIL b2b_result[%0d]: got %h, want %h", got, {cout, ovf, sum}, exp_r[got]);
                end
                got++;
            end
            prev_ready = in_ready;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (got != 3 || acc != 3) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d results %0d accepts, want 3 and 3", got, acc);
        end else begin
            n_cmp++;
            if (acc_cyc[1] - acc_cyc[0] != 6 || acc_cyc[2] - acc_cyc[1] != 6) begin
                n_bad++;
                $display("FAIL b2b_spacing: got %0d,%0d, want 6,6",
                         acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        if (!(in_ready === 1'b1 && out_valid === 1'b0 && sum === 16'h0)) n_bad++;
        test_add(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "basic");
        test_add(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple");
        test_add(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, "all_ones");
        test_add(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_pos");
        test_add(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "ovf_neg");
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit digits per operand; operand width W = 4*NIBBLES.
REQ-002 The block SHALL use one clock and a reset that is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operands and carry-in presented.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  W  operand A, unsigned or two's complement.
REQ-008 b  input  W  operand B.
REQ-009 cin  input  1  carry into nibble 0.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  W  a + b + cin, modulo 2^W.
REQ-013 cout  output  1  carry out of the MSB.
REQ-014 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-015 The block SHALL add one 4-bit nibble per cycle, LSB nibble first, through a single 4-bit carry-lookahead add (g = a&b, p = a|b, prefix carries, sum = a^b^carry).
REQ-016 The block SHALL implement states IDLE, ADD, DONE.
REQ-017 IDLE: in_ready=1, out_valid=0. On an edge with in_valid=1, it latches a, b, cin into internal registers, clears the nibble index and sum register, and moves to ADD.
REQ-018 ADD: in_ready=0, out_valid=0. On each edge it writes nibble[idx] = a_nib + b_nib + carry into the sum register, updates carry to the nibble carry-out, records the carry into bit 3 of the nibble when idx = NIBBLES-1, and increments idx.
REQ-019 After the edge that processes idx = NIBBLES-1, the block SHALL enter DONE; out_valid therefore rises exactly NIBBLES edges after the accepting edge.
REQ-020 DONE: out_valid=1, in_ready=0. sum, cout and ovf are driven from registers and SHALL be held stable while out_ready=0.
REQ-021 On an edge in DONE with out_ready=1, the block SHALL return to IDLE. Outputs keep their last values, and in_ready is 1 on the following cycle.
REQ-022 No new operands SHALL be accepted while in ADD or DONE. An in_valid held high during these states is accepted only on the first IDLE edge.
REQ-023 Input changes on a, b, cin after the accepting edge SHALL NOT affect the result.
REQ-024 Arithmetic: {cout, sum} = a + b + cin, exact for every value including all-ones operands with cin=1.
REQ-025 out_valid, in_ready, sum, cout and ovf SHALL be functions of registered state only; there is no combinational path from inputs to outputs.

Reset
REQ-026 While rst=1 at an edge, the block SHALL enter IDLE and clear sum, cout, ovf, carry, idx and the operand registers to 0. After the edge, in_ready=1 and out_valid=0.
REQ-027 rst SHALL take priority over in_valid and out_ready on the same edge.
REQ-028 A reset in ADD or DONE SHALL discard the operation without producing out_valid.

Verification (NIBBLES=4)
REQ-029 Basic add: accept a=0x1234, b=0x4321, cin=0 -> out_valid is high on the 4th edge after acceptance, sum=0x5555, cout=0, ovf=0.
REQ-030 Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Also a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0.
REQ-031 Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
REQ-032 Backpressure: hold out_ready=0 for 3 cycles in DONE -> sum, cout and ovf stay constant, out_valid=1 and in_ready=0 throughout. Then raise out_ready -> IDLE next cycle, and a new operand is accepted on the following edge.
REQ-033 Reset mid-operation: assert rst on the 2nd ADD edge -> next cycle in_ready=1, out_valid=0, sum=0; out_valid never rises for the aborted operation.
REQ-034 Back-to-back: keep in_valid=1 continuously with 3 different operand pairs and out_ready=1 -> each result appears once and in order, with acceptances spaced NIBBLES+2 edges apart.
